// File: rtl/tron_mem_responder.sv
// Memory-side responder for the Tron CPU: serves fetch/LOAD reads and STOR writes with
// a ready handshake and WAIT_CYCLES wait states, plus a side-band loader write port.
module tron_mem_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           cpu_addr,
  input  logic [15:0]           cpu_wdata,
  input  logic                  cpu_we,
  input  logic                  cpu_re,
  output logic [15:0]           cpu_rdata,
  output logic                  cpu_ready,
  output logic                  addr_err,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [15:0]           load_data,
  output logic [15:0]           access_count
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            wcnt_q, wcnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  rd_q, rd_d;
  logic                  err_q, err_d;
  logic [15:0]           rdata_q, rdata_d;
  logic [15:0]           count_q, count_d;

  logic [15:0]           mem [DEPTH];

  logic                  req;
  logic                  in_range;
  logic                  cpu_wr;
  logic [15:0]           rd_val;

  assign req      = cpu_re | cpu_we;
  assign in_range = (cpu_addr >> ADDR_WIDTH) == 16'h0000;
  // Writes commit at the sample edge itself, so only a clean, in-range STOR seen in IDLE writes.
  assign cpu_wr   = (state_q == S_IDLE) && cpu_we && !cpu_re && in_range && !reset;
  // Asynchronous read keeps loader writes landing during WAIT visible in the RESP data.
  assign rd_val   = err_q ? '0 : mem[addr_q];

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d = cpu_addr[ADDR_WIDTH-1:0];
          rd_d   = cpu_re;
          err_d  = (cpu_re && cpu_we) || !in_range;
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            wcnt_d  = 4'(WAIT_CYCLES);
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        wcnt_d = wcnt_q - 4'd1;
        if (wcnt_q == 4'd1) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        count_d = count_q + 16'd1;
        if (rd_q) begin
          rdata_d = rd_val;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end else if (cpu_wr) begin
      mem[cpu_addr[ADDR_WIDTH-1:0]] <= cpu_wdata;
    end
  end

  assign cpu_ready    = (state_q == S_RESP);
  assign addr_err     = (state_q == S_RESP) && err_q;
  assign cpu_rdata    = (state_q == S_RESP) ? rdata_d : rdata_q;
  assign access_count = count_q;

endmodule

// File: tb/tb_tron_mem_responder.sv
// Directed bench for tron_mem_responder: instance 0 has no wait states, instance 1 has three.
module tb_tron_mem_responder;

  logic        clk;
  logic        reset;
  logic [15:0] addr  [2];
  logic [15:0] wdata [2];
  logic        we    [2];
  logic        re    [2];
  logic [15:0] rdata [2];
  logic        rdy   [2];
  logic        err   [2];
  logic        len   [2];
  logic [9:0]  laddr [2];
  logic [15:0] ldata [2];
  logic [15:0] cnt   [2];

  int passed = 0;
  int total  = 0;

  tron_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .cpu_addr(addr[0]), .cpu_wdata(wdata[0]), .cpu_we(we[0]), .cpu_re(re[0]),
    .cpu_rdata(rdata[0]), .cpu_ready(rdy[0]), .addr_err(err[0]),
    .load_en(len[0]), .load_addr(laddr[0]), .load_data(ldata[0]),
    .access_count(cnt[0])
  );

  tron_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(3)) u_dut1 (
    .clk(clk), .reset(reset),
    .cpu_addr(addr[1]), .cpu_wdata(wdata[1]), .cpu_we(we[1]), .cpu_re(re[1]),
    .cpu_rdata(rdata[1]), .cpu_ready(rdy[1]), .addr_err(err[1]),
    .load_en(len[1]), .load_addr(laddr[1]), .load_data(ldata[1]),
    .access_count(cnt[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic load(input int d, input logic [9:0] a, input logic [15:0] v);
    @(negedge clk);
    len[d] = 1'b1; laddr[d] = a; ldata[d] = v;
    @(negedge clk);
    len[d] = 1'b0;
  endtask

  // Counts cycles from the request's sample edge to the first cpu_ready; -1 on timeout.
  task automatic wait_ready(input int d, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rdy[d] && lat < 40);
    if (!rdy[d]) lat = -1;
  endtask

  task automatic access(input int d, input logic [15:0] a, input logic [15:0] wd,
                        input logic r, input logic w,
                        output logic [15:0] data, output logic e, output int lat);
    @(negedge clk);
    addr[d] = a; wdata[d] = wd; re[d] = r; we[d] = w;
    wait_ready(d, lat);
    data  = rdata[d];
    e     = err[d];
    re[d] = 1'b0; we[d] = 1'b0;
    @(negedge clk);
    check("single_pulse", 16'(rdy[d]), 16'h0);
  endtask

  initial begin
    logic [15:0] data;
    logic        e;
    int          lat;
    int          pulses;

    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      addr[i] = '0; wdata[i] = '0; we[i] = 1'b0; re[i] = 1'b0;
      len[i] = 1'b0; laddr[i] = '0; ldata[i] = '0;
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_ready", 16'(rdy[0]), 16'h0);
    check("rst_err", 16'(err[1]), 16'h0);
    check("rst_rdata", rdata[0], 16'h0000);
    check("rst_count", cnt[1], 16'h0000);

    // Basic reads with zero wait states
    load(0, 10'd0, 16'h0152);
    load(0, 10'd1, 16'h5193);
    access(0, 16'h0000, 16'h0, 1'b1, 1'b0, data, e, lat);
    check("t1_lat0", 16'(lat), 16'd1);
    check("t1_rd0", data, 16'h0152);
    check("t1_err0", 16'(e), 16'h0);
    access(0, 16'h0001, 16'h0, 1'b1, 1'b0, data, e, lat);
    check("t1_rd1", data, 16'h5193);
    check("t1_count", cnt[0], 16'd2);

    // CPU write then readback; write leaves held read data alone
    access(0, 16'h0004, 16'h0005, 1'b0, 1'b1, data, e, lat);
    check("t2_wr_err", 16'(e), 16'h0);
    check("t2_wr_hold", data, 16'h5193);
    access(0, 16'h0004, 16'h0, 1'b1, 1'b0, data, e, lat);
    check("t2_rd", data, 16'h0005);
    check("t2_rd_err", 16'(e), 16'h0);
    check("t2_count", cnt[0], 16'd4);

    // Three wait states, and a held request is only re-sampled after returning to IDLE
    load(1, 10'd2, 16'h1234);
    access(1, 16'h0002, 16'h0, 1'b1, 1'b0, data, e, lat);
    check("t3_lat3", 16'(lat), 16'd4);
    check("t3_rd", data, 16'h1234);
    @(negedge clk);
    addr[1] = 16'h0002; re[1] = 1'b1;
    wait_ready(1, lat);
    check("t3_hold_lat", 16'(lat), 16'd4);
    wait_ready(1, lat);
    check("t3_gap", 16'(lat), 16'd5);
    re[1] = 1'b0;
    @(negedge clk);
    check("t3_count", cnt[1], 16'd3);

    // Error cases on the 10-bit instance
    access(0, 16'h0400, 16'h0, 1'b1, 1'b0, data, e, lat);
    check("t4_oor_rd", data, 16'h0000);
    check("t4_oor_rd_err", 16'(e), 16'h1);
    access(0, 16'h8000, 16'hFFFF, 1'b0, 1'b1, data, e, lat);
    check("t4_oor_wr_err", 16'(e), 16'h1);
    check("t4_oor_wr_lat", 16'(lat), 16'd1);
    access(0, 16'h0000, 16'h0, 1'b1, 1'b0, data, e, lat);
    check("t4_mem0_kept", data, 16'h0152);
    access(0, 16'h0001, 16'hDEAD, 1'b1, 1'b1, data, e, lat);
    check("t4_both_err", 16'(e), 16'h1);
    check("t4_both_rdata", data, 16'h0000);
    access(0, 16'h0001, 16'h0, 1'b1, 1'b0, data, e, lat);
    check("t4_mem1_kept", data, 16'h5193);
    check("t4_count", cnt[0], 16'd9);

    // Reset during WAIT aborts the read silently
    @(negedge clk);
    addr[1] = 16'h0002; re[1] = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1; re[1] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rdy[1] || err[1]) pulses++;
    end
    check("t5_no_pulse", 16'(pulses), 16'd0);
    check("t5_rdata", rdata[1], 16'h0000);
    check("t5_count", cnt[1], 16'h0000);
    access(1, 16'h0002, 16'h0, 1'b1, 1'b0, data, e, lat);
    check("t5_mem_kept", data, 16'h1234);

    // Loader wins a same-edge write collision
    @(negedge clk);
    len[0] = 1'b1; laddr[0] = 10'h010; ldata[0] = 16'hAAAA;
    addr[0] = 16'h0010; wdata[0] = 16'h5555; we[0] = 1'b1;
    @(negedge clk);
    len[0] = 1'b0;
    check("t6_wr_ready", 16'(rdy[0]), 16'h1);
    we[0] = 1'b0;
    @(negedge clk);
    access(0, 16'h0010, 16'h0, 1'b1, 1'b0, data, e, lat);
    check("t6_loader_wins", data, 16'hAAAA);

    // Counter wrap: preset near the top instead of spending 65535 transactions
    force u_dut0.count_q = 16'hFFFF;
    #1;
    release u_dut0.count_q;
    check("t6_count_top", cnt[0], 16'hFFFF);
    access(0, 16'h0001, 16'h0, 1'b1, 1'b0, data, e, lat);
    check("t6_count_wrap", cnt[0], 16'h0000);
    check("t6_wrap_rd", data, 16'h5193);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
